// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle RV32M MUL/DIV controller for the EX stage. Operands are
//   latched on acceptance. A shared accumulator then runs one bit per cycle,
//   using shift-add for multiply and restoring shift-subtract for divide.
//   Signs and corner cases are resolved in a single fixup cycle.
//
//   Optional feature: define MULDIV_EARLY_OUT_EN to skip the iterative phase
//   for zero-operand multiplies and divide-by-zero.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-low
//   start   in   M-extension op present in EX; held until done
//   Funct3  in   op select (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
//   SrcA    in   rs1: multiplicand / dividend
//   SrcB    in   rs2: multiplier / divisor
//   flush   in   abort any in-flight op; wins over start
//   busy    out  op accepted and not yet completed
//   stall   out  start & ~done, freezes the front of the pipeline
//   done    out  one-cycle pulse, Result valid this cycle
//   Result  out  selected product half / quotient / remainder
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] Result
);
    localparam int unsigned      CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2:0]         f3_q, f3_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;      // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] acc_q, acc_d;        // {hi|rem, lo|quot}
    logic               neg_q, neg_d;        // final result must be negated
    logic [WIDTH-1:0]   result_q, result_d;

    logic               sgn_a, sgn_b, neg_a, neg_b, early, ovf;
    logic [WIDTH-1:0]   abs_a, abs_b, quot, rem;
    logic [WIDTH:0]     sum, shifted, diff;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        f3_d     = f3_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;

        // Operand signedness from Funct3: DIV/REM signed, DIVU/REMU unsigned;
        // A is signed for MUL/MULH/MULHSU, B only for MUL/MULH.
        sgn_a = Funct3[2] ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
        sgn_b = Funct3[2] ? ~Funct3[0] : ~Funct3[1];
        neg_a = sgn_a & SrcA[WIDTH-1];
        neg_b = sgn_b & SrcB[WIDTH-1];
        abs_a = neg_a ? -SrcA : SrcA;
        abs_b = neg_b ? -SrcB : SrcB;

        early = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        early = Funct3[2] ? (SrcB == '0) : ((SrcA == '0) || (SrcB == '0));
`endif

        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        shifted = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, opnd_q};

        prod = neg_q ? -acc_q : acc_q;
        quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        ovf  = ~f3_q[0] & (a_q == MIN_NEG) & (b_q == '1);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    f3_d    = Funct3;
                    a_d     = SrcA;
                    b_d     = SrcB;
                    // Remainder follows the dividend sign; all others use the sign product.
                    neg_d   = (Funct3[2] & Funct3[1]) ? neg_a : (neg_a ^ neg_b);
                    opnd_d  = Funct3[2] ? abs_b : abs_a;
                    acc_d   = {{WIDTH{1'b0}}, (Funct3[2] ? abs_a : abs_b)};
                    count_d = '0;
                    state_d = S_CALC;
                    if (early) begin
                        // Zero accumulator gives a zero product; divide-by-zero is overridden in FIX.
                        acc_d   = '0;
                        state_d = S_FIX;
                    end
                end
            end
            S_CALC: begin
                if (f3_q[2]) begin
                    // Restoring step: keep the difference only when it did not go negative.
                    if (!diff[WIDTH])
                        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
                end
                count_d = count_q + CW'(1);
                if (count_q == LAST)
                    state_d = S_FIX;
            end
            S_FIX: begin
                unique case (f3_q)
                    3'b000:                result_d = prod[WIDTH-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod[2*WIDTH-1:WIDTH];
                    3'b100, 3'b101: begin
                        if (b_q == '0)  result_d = '1;
                        else if (ovf)   result_d = a_q;
                        else            result_d = quot;
                    end
                    default: begin
                        if (b_q == '0)  result_d = a_q;
                        else if (ovf)   result_d = '0;
                        else            result_d = rem;
                    end
                endcase
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign stall  = start & ~done;
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    localparam int unsigned WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;
    logic        busy, stall, done;
    logic [31:0] Result;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .Result(Result)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level expectations: busy over [m_acc, m_end], done at m_done.
    int          m_acc = 1, m_end = 0, m_done = -1;
    logic [31:0] m_res = '0, m_lit = '0;
    bit          m_lit_en = 0, chk_on = 0;
    int          n_tests = 0, n_fail = 0;

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit early_out(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit en;
`ifdef MULDIV_EARLY_OUT_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && (f3[2] ? (b == 0) : (a == 0 || b == 0));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", 32'(busy), 32'(cyc >= m_acc && cyc <= m_end));
            chk("done", 32'(done), 32'(cyc == m_done));
            chk("stall", 32'(stall), 32'(start && cyc != m_done));
            chk("Result", Result, m_res);
            if (cyc == m_done && m_lit_en)
                chk("literal", Result, m_lit);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves start high on return (cycle after DONE); caller drops it or issues the next op.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit lit_en, input logic [31:0] lit);
        int s, lat;
        logic [31:0] e;
        s   = cyc;
        e   = model(f3, a, b);
        lat = early_out(f3, a, b) ? 2 : WIDTH + 2;
        start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
        m_acc = s + 1; m_end = s + lat; m_done = s + lat;
        m_lit_en = lit_en; m_lit = lit;
        for (int i = 0; i < lat; i++) begin
            tick();
            Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
        end
        m_res = e;
        tick();
    endtask

    task automatic abort_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input int k, input bit use_reset);
        int s;
        s = cyc;
        start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
        m_acc = s + 1; m_end = s + WIDTH + 2; m_done = s + WIDTH + 2; m_lit_en = 0;
        repeat (k) tick();
        start = 1'b0;
        if (use_reset) reset = 1'b0; else flush = 1'b1;
        m_end = s + k; m_done = -1;
        tick();
        reset = 1'b1; flush = 1'b0;
        if (use_reset) m_res = '0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; flush = 1'b0;
        Funct3 = '0; SrcA = '0; SrcB = '0;
        tick();
        chk_on = 1;
        tick();
        reset = 1'b1;
        tick();

        do_op(3'd0, 32'd7, 32'hFFFFFFFD, 1, 32'hFFFFFFEB);
        start = 1'b0; tick();
        do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE);
        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000);
        start = 1'b0; tick();
        do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
        do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000);
        do_op(3'd4, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFD);
        do_op(3'd6, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF);
        start = 1'b0; tick();
        do_op(3'd5, 32'd5, 32'd0, 1, 32'hFFFFFFFF);
        do_op(3'd7, 32'd5, 32'd0, 1, 32'd5);
        start = 1'b0; tick();

        abort_op(3'd4, 32'd100, 32'd7, 10, 0);
        do_op(3'd0, 32'd3, 32'd4, 1, 32'd12);
        start = 1'b0; tick(); tick();

        // flush and start together in IDLE: nothing accepted
        start = 1'b1; flush = 1'b1; Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd9;
        tick();
        start = 1'b0; flush = 1'b0;
        tick(); tick();

        abort_op(3'd0, 32'd12345, 32'd678, 10, 1);
        do_op(3'd2, 32'hFFFFFFF0, 32'd3, 1, 32'hFFFFFFFF);
        do_op(3'd5, 32'd100, 32'd7, 1, 32'd14);
        start = 1'b0; tick();

        for (int n = 0; n < 40; n++) begin
            do_op(3'($urandom_range(0, 7)), pick(), pick(), 0, 32'h0);
            if ($urandom_range(0, 1) == 1) begin
                start = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        start = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
